// File: rtl/addr_reg_bank_if.sv
// rtl/addr_reg_bank_if.sv - control/status bundle for the per-core address register bank
//
// Signals (flat, channel i occupies slice i of each bus):
//   clr_en     [N_CORES]           per-channel clear
//   write_en   [N_CORES]           per-channel load from own datain slice
//   inc_en     [N_CORES]           per-channel increment by own stride
//   bcast_en                       load datain slice 0 into every channel
//   datain     [N_CORES*DATA_W]    load buses
//   stride     [N_CORES*STRIDE_W]  increment amounts
//   dataout    [N_CORES*ADDR_W]    registered addresses
//   bound_flag [N_CORES]           sticky limit-crossing flags
//   any_bound                      registered OR of bound_flag
// master = control unit side, slave = register bank side.
interface addr_reg_bank_if #(
  parameter int N_CORES  = 4,
  parameter int DATA_W   = 17,
  parameter int ADDR_W   = 12,
  parameter int STRIDE_W = 4
);
  logic [N_CORES-1:0]          clr_en;
  logic [N_CORES-1:0]          write_en;
  logic [N_CORES-1:0]          inc_en;
  logic                        bcast_en;
  logic [N_CORES*DATA_W-1:0]   datain;
  logic [N_CORES*STRIDE_W-1:0] stride;
  logic [N_CORES*ADDR_W-1:0]   dataout;
  logic [N_CORES-1:0]          bound_flag;
  logic                        any_bound;

  modport master (
    output clr_en, write_en, inc_en, bcast_en, datain, stride,
    input  dataout, bound_flag, any_bound
  );

  modport slave (
    input  clr_en, write_en, inc_en, bcast_en, datain, stride,
    output dataout, bound_flag, any_bound
  );
endinterface

// File: rtl/addr_reg_bank.sv
// rtl/addr_reg_bank.sv - N_CORES independent address registers with stride, wrap/saturate and sticky bound flags
//
// Ports:
//   clk    system clock, all updates on the rising edge
//   rst_n  synchronous active-low reset
//   bus    addr_reg_bank_if.slave (enables, load/stride buses in; addresses and flags out)
// Per-channel priority: rst_n, clr_en, bcast_en, write_en, inc_en.
// STRIDE_W must not exceed ADDR_W.
module addr_reg_bank #(
  parameter int N_CORES    = 4,
  parameter int DATA_W     = 17,
  parameter int ADDR_W     = 12,
  parameter int ADDR_LIMIT = 4095,
  parameter int STRIDE_W   = 4,
  parameter int WRAP_MODE  = 1
) (
  input logic            clk,
  input logic            rst_n,
  addr_reg_bank_if.slave bus
);

  // Limit and wrap span held one bit wider than the address so the sum compares exactly.
  localparam logic [ADDR_W:0]   LIMIT_X = (ADDR_W+1)'(ADDR_LIMIT);
  localparam logic [ADDR_W:0]   SPAN_X  = (ADDR_W+1)'(ADDR_LIMIT + 1);
  localparam logic [ADDR_W-1:0] LIMIT_A = ADDR_W'(ADDR_LIMIT);

  logic [ADDR_W-1:0]   addr_q   [N_CORES];
  logic [ADDR_W-1:0]   addr_d   [N_CORES];
  logic [ADDR_W:0]     sum_w    [N_CORES];
  logic [ADDR_W-1:0]   wrap_w   [N_CORES];
  logic [STRIDE_W-1:0] stride_w [N_CORES];
  logic [N_CORES-1:0]  flag_q;
  logic [N_CORES-1:0]  flag_d;
  logic                any_q;
  logic [N_CORES*ADDR_W-1:0] dataout_flat;

  // Only the low ADDR_W bits of each load slice are architectural.
  logic [N_CORES*DATA_W-1:0] unused_datain;
  assign unused_datain = bus.datain;

  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      stride_w[i] = bus.stride[i*STRIDE_W +: STRIDE_W];
      sum_w[i]    = {1'b0, addr_q[i]} + {{(ADDR_W+1-STRIDE_W){1'b0}}, stride_w[i]};
      wrap_w[i]   = ADDR_W'(sum_w[i] - SPAN_X);
    end
  end

  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      addr_d[i] = addr_q[i];
      flag_d[i] = flag_q[i];
      if (bus.clr_en[i]) begin
        addr_d[i] = '0;
        flag_d[i] = 1'b0;
      end else if (bus.bcast_en) begin
        addr_d[i] = bus.datain[ADDR_W-1:0];
        flag_d[i] = 1'b0;
      end else if (bus.write_en[i]) begin
        addr_d[i] = bus.datain[i*DATA_W +: ADDR_W];
        flag_d[i] = 1'b0;
      end else if (bus.inc_en[i] && (stride_w[i] != '0)) begin
        // Zero stride is a pure hold, even if a loaded value already sits above the limit.
        if (sum_w[i] <= LIMIT_X) begin
          addr_d[i] = sum_w[i][ADDR_W-1:0];
        end else begin
          flag_d[i] = 1'b1;
          addr_d[i] = (WRAP_MODE != 0) ? wrap_w[i] : LIMIT_A;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CORES; i++) begin
        addr_q[i] <= '0;
      end
      flag_q <= '0;
      any_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        addr_q[i] <= addr_d[i];
      end
      flag_q <= flag_d;
      // Built from the registered flags, so it trails bound_flag by one cycle.
      any_q  <= |flag_q;
    end
  end

  always_comb begin
    dataout_flat = '0;
    for (int i = 0; i < N_CORES; i++) begin
      dataout_flat[i*ADDR_W +: ADDR_W] = addr_q[i];
    end
  end

  assign bus.dataout    = dataout_flat;
  assign bus.bound_flag = flag_q;
  assign bus.any_bound  = any_q;

endmodule
